// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: FSM states, redirect sources and default vectors.
// Redirect sources are ordered so that a larger encoding means higher priority.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    JUMP   = 2'd1,
    BRANCH = 2'd2,
    EXC    = 2'd3
  } redir_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

  // An arriving redirect replaces a pending one when it is at least as urgent,
  // except that a pending exception is sticky.
  function automatic logic may_overwrite(input redir_t pend, input redir_t arr);
    return (arr != NONE) && (pend != EXC) && (arr >= pend);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_plus4.sv
// Sequential-PC adder; wraps modulo 2^32.
module pc_plus4 (
  input  logic [31:0] pc,
  output logic [31:0] pc4
);

  assign pc4 = pc + 32'd4;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer (IDLE -> REQ -> VALID).
// Build option PC_ALIGN_CHECK_EN: misaligned branch/jump targets raise an exception and pulse addr_err.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
`ifdef PC_ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  output logic [31:0] epc
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] epc_reg, epc_next;
  redir_t      pend_src_reg, pend_src_next;
  logic [31:0] pend_tgt_reg, pend_tgt_next;
  logic [31:0] pc4_w;

  redir_t      arr_src, eff_src;
  logic [31:0] arr_tgt, eff_tgt;
  logic        arr_accept;

  // Index 0 = jump, 1 = branch.
  logic [31:0] raw_tgt [2];
  logic [31:0] al_tgt  [2];
`ifdef PC_ALIGN_CHECK_EN
  logic [1:0]  misalign;
  logic        align_fault;
  logic        addr_err_reg, addr_err_next;
`endif

  assign raw_tgt[0] = jump_target;
  assign raw_tgt[1] = branch_target;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tgt
      assign al_tgt[gi] = raw_tgt[gi] & ~32'h3;
`ifdef PC_ALIGN_CHECK_EN
      assign misalign[gi] = |raw_tgt[gi][1:0];
`endif
    end
  endgenerate

  pc_plus4 u_pc_plus4 (
    .pc  (pc_reg),
    .pc4 (pc4_w)
  );

  // Resolve this cycle's redirect request by priority exception > branch > jump.
  always_comb begin
    arr_src = NONE;
    arr_tgt = EXC_VECTOR;
`ifdef PC_ALIGN_CHECK_EN
    align_fault = 1'b0;
`endif
    if (exception) begin
      arr_src = EXC;
    end else if (branch_taken) begin
      arr_src = BRANCH;
      arr_tgt = al_tgt[1];
`ifdef PC_ALIGN_CHECK_EN
      if (misalign[1]) begin
        arr_src     = EXC;
        arr_tgt     = EXC_VECTOR;
        align_fault = 1'b1;
      end
`endif
    end else if (jump) begin
      arr_src = JUMP;
      arr_tgt = al_tgt[0];
`ifdef PC_ALIGN_CHECK_EN
      if (misalign[0]) begin
        arr_src     = EXC;
        arr_tgt     = EXC_VECTOR;
        align_fault = 1'b1;
      end
`endif
    end
  end

  assign arr_accept = may_overwrite(pend_src_reg, arr_src);
  assign eff_src    = arr_accept ? arr_src : pend_src_reg;
  assign eff_tgt    = arr_accept ? arr_tgt : pend_tgt_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    epc_next      = epc_reg;
    pend_src_next = pend_src_reg;
    pend_tgt_next = pend_tgt_reg;
`ifdef PC_ALIGN_CHECK_EN
    addr_err_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
`ifdef PC_ALIGN_CHECK_EN
        addr_err_next = align_fault && arr_accept;
`endif
        if (imem_ack) begin
          if (eff_src != NONE) begin
            // Fetched word is squashed; refetch from the redirect target.
            pc_next       = eff_tgt;
            pend_src_next = NONE;
            if (eff_src == EXC) epc_next = pc_reg;
          end else begin
            state_next = VALID;
          end
        end else if (arr_accept) begin
          pend_src_next = arr_src;
          pend_tgt_next = arr_tgt;
        end
      end
      VALID: begin
`ifdef PC_ALIGN_CHECK_EN
        addr_err_next = align_fault;
`endif
        if (arr_src != NONE) begin
          pc_next    = arr_tgt;
          state_next = REQ;
          if (arr_src == EXC) epc_next = pc_reg;
        end else if (!stall) begin
          pc_next    = pc4_w;
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_VECTOR;
      epc_reg      <= 32'h0;
      pend_src_reg <= NONE;
      pend_tgt_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      epc_reg      <= epc_next;
      pend_src_reg <= pend_src_next;
      pend_tgt_reg <= pend_tgt_next;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_reg <= 1'b0;
    else        addr_err_reg <= addr_err_next;
  end
  assign addr_err = addr_err_reg;
`endif

  assign imem_req    = (state_reg == REQ);
  assign instr_valid = (state_reg == VALID);
  assign imem_addr   = pc_reg;
  assign pc_out      = pc_reg;
  assign pc4_out     = pc4_w;
  assign epc         = epc_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: stimulus pushes expected fetch addresses and
// valid PCs; a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken, jump, exception, imem_ack;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc_out, pc4_out, epc;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] fetch_q [$];
  logic [31:0] valid_q [$];
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .pc4_out       (pc4_out),
`ifdef PC_ALIGN_CHECK_EN
    .addr_err      (addr_err),
`endif
    .epc           (epc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total_cnt++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  // Monitor: one pop per accepted fetch, one pop per new instruction shown to decode.
  always @(negedge clk) begin
    logic [31:0] e;
    if (imem_req && imem_ack) begin
      if (fetch_q.size() == 0) fail_now("unexpected_fetch", imem_addr);
      else begin
        e = fetch_q.pop_front();
        chk("fetch_addr", imem_addr, e);
      end
    end
    if (instr_valid && !prev_valid) begin
      if (valid_q.size() == 0) fail_now("unexpected_valid", pc_out);
      else begin
        e = valid_q.pop_front();
        chk("valid_pc", pc_out, e);
        chk("valid_pc4", pc4_out, e + 32'd4);
      end
    end
    prev_valid = instr_valid;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (instr_valid && pc_out == addr) found = 1'b1;
    end
    if (!found) fail_now("timeout_wait_valid", addr);
  endtask

  task automatic push(input logic [31:0] a, input bit shown);
    fetch_q.push_back(a);
    if (shown) valid_q.push_back(a);
  endtask

  logic [31:0] align_exp;

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; exception = 1'b0;
    imem_ack = 1'b1; branch_target = 32'h0; jump_target = 32'h0;
    cyc(); cyc();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_epc", epc, 32'h0);

    // Zero-wait sequential fetch from the reset vector
    push(32'h0, 1); push(32'h4, 1); push(32'h8, 1);
    rst_n = 1'b1;
    cyc();
    chk("first_req", {31'h0, imem_req}, 32'h1);
    wait_valid(32'h8);

    // Stall holds VALID for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_noreq", {31'h0, imem_req}, 32'h0);
    end
    push(32'hC, 1);
    stall = 1'b0;
    wait_valid(32'hC);

    // Branch while REQ with delayed ack: 0x10 squashed, refetch 0x100
    push(32'h10, 0); push(32'h100, 1);
    imem_ack = 1'b0;
    cyc();
    branch_taken = 1'b1; branch_target = 32'h100;
    cyc();
    branch_taken = 1'b0;
    cyc();
    imem_ack = 1'b1;
    wait_valid(32'h100);

    // Jump to 0x20, then simultaneous exception/branch/jump
    push(32'h20, 1);
    jump = 1'b1; jump_target = 32'h20;
    cyc();
    jump = 1'b0;
    wait_valid(32'h20);
    push(32'h80, 1);
    exception = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    jump = 1'b1; jump_target = 32'h400;
    cyc();
    exception = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    chk("exc_addr", imem_addr, 32'h80);
    chk("exc_epc", epc, 32'h20);
    wait_valid(32'h80);

    // Wraparound from the top of the address space
    push(32'hFFFF_FFFC, 1); push(32'h0, 1);
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    cyc();
    jump = 1'b0;
    wait_valid(32'h0);

    // Pending exception is not overwritten by a later branch
    push(32'h4, 0); push(32'h80, 1);
    imem_ack = 1'b0;
    cyc();
    exception = 1'b1;
    cyc();
    exception = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    cyc();
    branch_taken = 1'b0; imem_ack = 1'b1;
    cyc();
    chk("pend_exc_addr", imem_addr, 32'h80);
    chk("pend_exc_epc", epc, 32'h4);
    wait_valid(32'h80);

    // Pending jump is overwritten by a higher-priority branch
    push(32'h84, 0); push(32'h600, 1);
    imem_ack = 1'b0;
    cyc();
    jump = 1'b1; jump_target = 32'h500;
    cyc();
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h600;
    cyc();
    branch_taken = 1'b0; imem_ack = 1'b1;
    cyc();
    chk("pend_br_addr", imem_addr, 32'h600);
    wait_valid(32'h600);

    // Misaligned jump target
`ifdef PC_ALIGN_CHECK_EN
    align_exp = 32'h80;
`else
    align_exp = 32'h100;
`endif
    push(align_exp, 1);
    jump = 1'b1; jump_target = 32'h102;
    cyc();
    jump = 1'b0;
    chk("align_addr", imem_addr, align_exp);
`ifdef PC_ALIGN_CHECK_EN
    chk("align_err", {31'h0, addr_err}, 32'h1);
    chk("align_epc", epc, 32'h600);
    cyc();
    chk("align_err_pulse", {31'h0, addr_err}, 32'h0);
`endif
    wait_valid(align_exp);

    // Asynchronous reset during REQ
    imem_ack = 1'b0;
    cyc();
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_epc", epc, 32'h0);
    imem_ack = 1'b1;
    cyc(); cyc();
    push(32'h0, 1);
    rst_n = 1'b1;
    wait_valid(32'h0);
    imem_ack = 1'b0;
    cyc(); cyc(); cyc();
    chk("fetch_q_empty", fetch_q.size(), 32'h0);
    chk("valid_q_empty", valid_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
